gpio_ctrl: RTL
==============

Name: gpio_ctrl

Overview:
- Parametrised GPIO peripheral for the RISC-V SoC; next generation of the fixed 4-pin gpio_pins port on RISC_V_SOC_TOP.
- Provides GPIO_W pins with per-pin direction, input synchroniser, per-pin rise/fall edge interrupts and a valid/ready register interface.
- Sits on the SoC peripheral bus beside the UART. Pad tristates are built in the SoC top from gpio_out/gpio_oe.

Parameters:
- GPIO_W, 4, number of pins; legal range 1..32.
- ADDR_W, 8, register byte-address width.
- DEBOUNCE_CYC, 16, stable cycles required before an input change is accepted; used only with GPIO_DEBOUNCE_EN.

Ports:
- sys_clk  in  1  system clock.
- sys_reset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  bus request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  unmapped address.
- gpio_in  in  GPIO_W  raw pad inputs, asynchronous.
- gpio_out  out  GPIO_W  output data.
- gpio_oe  out  GPIO_W  output enable, 1 = drive.
- irq  out  1  level interrupt to the core.

Behaviour:
- Register map (word offsets):
  - 0x00 OUT (RW)
  - 0x04 DIR (RW, 1 = output)
  - 0x08 IN (RO, synchronised/filtered value)
  - 0x0C IRQ_EN (RW)
  - 0x10 RISE_EN (RW)
  - 0x14 FALL_EN (RW)
  - 0x18 STATUS (RW1C)
- Register width rules: bits >= GPIO_W read 0; writes to those bits are ignored.
- Reset (sys_reset low, async) clears all registers and outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, gpio_oe=0, irq=0, synchroniser/edge flops=0.
- Bus FSM, state IDLE:
  - req_ready=1.
  - On accept: a write updates the register at that edge; a read captures rsp_rdata at that edge; next state RESP.
- Bus FSM, state RESP:
  - req_ready=0, rsp_valid=1.
  - Holds rsp_rdata/rsp_err stable until rsp_ready; then returns to IDLE.
  - Minimum throughput: 1 transaction per 2 cycles.
- Unmapped address: read returns 0, write is ignored, rsp_err=1 with the response.
- Write to IN: ignored, rsp_err=0.
- Output path: gpio_out=OUT and gpio_oe=DIR, registered, so they change 1 cycle after a write is accepted.
- Input path:
  - 2-flop synchroniser, then a prev register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - A level sampled at edge k appears in IN at edge k+1 and sets STATUS at edge k+2.
- STATUS[i] set condition: (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]). STATUS is set regardless of IRQ_EN.
- STATUS write-1-to-clear. A set and a W1C of the same bit in the same cycle: set wins, bit stays 1.
- irq = |(STATUS & IRQ_EN), registered (1 cycle after STATUS).
- Output-configured pins still sample gpio_in, so loopback edges are reported.

Optional Feature:
- GPIO_DEBOUNCE_EN defined:
  - Per-pin counter of width clog2(DEBOUNCE_CYC+1) sits after the synchroniser.
  - Filtered value updates only after the synced input differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any bounce back resets the counter to 0.
  - Edge detect and IN use the filtered value, adding DEBOUNCE_CYC cycles of latency.
- GPIO_DEBOUNCE_EN undefined: no counters; synced value used directly; DEBOUNCE_CYC unused.

Decomposition:
- Shared package gpio_pkg: register offset constants (GPIO_OUT_OFF..GPIO_STATUS_OFF) and the bus FSM state enum {IDLE, RESP}.
- One sub-module gpio_in_filter (per-pin synchroniser + optional debounce), instantiated GPIO_W times via generate.

Test Plan:
- Reset: hold sys_reset=0 mid-transaction → all outputs 0 immediately; after release, IN read returns 0 and rsp_err=0.
- Output, GPIO_W=4:
  - Write DIR=0xF, then OUT=0xA → gpio_oe=4'hF, gpio_out=4'hA one cycle after each accept.
  - Write OUT=0xFFFF_FFFA → reads back 0x0000_000A.
- Rising edge: RISE_EN=0x1, IRQ_EN=0x1, gpio_in 0→1 on pin0 → STATUS=0x1 at edge k+2, irq=1 at k+3; W1C 0x1 → irq drops.
- Simultaneous set/clear: pin1 falling edge (FALL_EN=0x2) arrives in the same cycle as a STATUS write of 0x2 → STATUS[1] remains 1.
- Handshake: read with rsp_ready held low 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout; read of 0x40 → rsp_rdata=0, rsp_err=1.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CYC=16: pulse of 10 cycles → no IN change, no STATUS; level held 20 cycles → IN updates after 16 stable cycles.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register byte offsets and bus FSM states.
package gpio_pkg;

   localparam int unsigned GPIO_OUT_OFF    = 32'h00;
   localparam int unsigned GPIO_DIR_OFF    = 32'h04;
   localparam int unsigned GPIO_IN_OFF     = 32'h08;
   localparam int unsigned GPIO_IRQ_EN_OFF = 32'h0C;
   localparam int unsigned GPIO_RISE_OFF   = 32'h10;
   localparam int unsigned GPIO_FALL_OFF   = 32'h14;
   localparam int unsigned GPIO_STATUS_OFF = 32'h18;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } bus_state_t;

endpackage

// File: rtl/gpio_in_filter.sv
// One pad input: two-flop synchroniser, plus a stability filter when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic sys_clk,
   input  logic sys_reset,
   input  logic pin_in,
   output logic pin_out
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= pin_in;
         sync_reg <= meta_reg;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             filt_reg;

   // The counter tracks consecutive cycles of disagreement; any return to agreement restarts it.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         cnt_reg  <= '0;
         filt_reg <= 1'b0;
      end else if (sync_reg != filt_reg) begin
         if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
            filt_reg <= sync_reg;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   assign pin_out = filt_reg;
`else
   assign pin_out = sync_reg;
`endif

   generate
      if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
         $error("DEBOUNCE_CYC must be at least 1");
      end
   endgenerate

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: per-pin direction, synchronised inputs, rise/fall edge status and a level irq.
// Input debounce is added per pin when GPIO_DEBOUNCE_EN is defined.
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int GPIO_W       = 4,
   parameter int ADDR_W       = 8,
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic              sys_clk,
   input  logic              sys_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe,
   output logic              irq
);

   logic [GPIO_W-1:0] out_reg;
   logic [GPIO_W-1:0] dir_reg;
   logic [GPIO_W-1:0] irq_en_reg;
   logic [GPIO_W-1:0] rise_en_reg;
   logic [GPIO_W-1:0] fall_en_reg;
   logic [GPIO_W-1:0] status_reg;
   logic [GPIO_W-1:0] status_next;
   logic [GPIO_W-1:0] status_set;
   logic [GPIO_W-1:0] status_clr;
   logic [GPIO_W-1:0] gpio_out_reg;
   logic [GPIO_W-1:0] gpio_oe_reg;
   logic [GPIO_W-1:0] in_sync;
   logic [GPIO_W-1:0] in_prev_reg;
   logic [GPIO_W-1:0] rise;
   logic [GPIO_W-1:0] fall;

   logic              ready_reg;
   logic              irq_reg;
   logic              rsp_err_reg;
   logic [31:0]       rsp_rdata_reg;
   logic [31:0]       rd_mux;
   logic              addr_err;
   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] addr_word;
   logic              unused_bits;

   bus_state_t state_reg;
   bus_state_t state_next;

   generate
      if (GPIO_W < 1 || GPIO_W > 32) begin : g_bad_width
         $error("GPIO_W must be in 1..32");
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
         gpio_in_filter #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_filter (
            .sys_clk   (sys_clk),
            .sys_reset (sys_reset),
            .pin_in    (gpio_in[gi]),
            .pin_out   (in_sync[gi])
         );
      end
   endgenerate

   assign accept      = req_valid && req_ready;
   assign wr_en       = accept && req_we;
   assign addr_word   = {req_addr[ADDR_W-1:2], 2'b00};
   assign unused_bits = ^{req_addr[1:0], req_wdata};

   assign rise        = in_sync & ~in_prev_reg;
   assign fall        = ~in_sync & in_prev_reg;
   assign status_set  = (rise & rise_en_reg) | (fall & fall_en_reg);
   assign status_clr  = (wr_en && addr_word == ADDR_W'(GPIO_STATUS_OFF)) ?
                        req_wdata[GPIO_W-1:0] : '0;
   // A new edge in the same cycle as its clear keeps the bit set.
   assign status_next = (status_reg & ~status_clr) | status_set;

   always_comb begin
      rd_mux   = '0;
      addr_err = 1'b0;
      case (addr_word)
         ADDR_W'(GPIO_OUT_OFF):    rd_mux = 32'(out_reg);
         ADDR_W'(GPIO_DIR_OFF):    rd_mux = 32'(dir_reg);
         ADDR_W'(GPIO_IN_OFF):     rd_mux = 32'(in_sync);
         ADDR_W'(GPIO_IRQ_EN_OFF): rd_mux = 32'(irq_en_reg);
         ADDR_W'(GPIO_RISE_OFF):   rd_mux = 32'(rise_en_reg);
         ADDR_W'(GPIO_FALL_OFF):   rd_mux = 32'(fall_en_reg);
         ADDR_W'(GPIO_STATUS_OFF): rd_mux = 32'(status_reg);
         default:                  addr_err = 1'b1;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         out_reg       <= '0;
         dir_reg       <= '0;
         irq_en_reg    <= '0;
         rise_en_reg   <= '0;
         fall_en_reg   <= '0;
         status_reg    <= '0;
         in_prev_reg   <= '0;
         gpio_out_reg  <= '0;
         gpio_oe_reg   <= '0;
         irq_reg       <= 1'b0;
         ready_reg     <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         if (wr_en && addr_word == ADDR_W'(GPIO_OUT_OFF))    out_reg     <= req_wdata[GPIO_W-1:0];
         if (wr_en && addr_word == ADDR_W'(GPIO_DIR_OFF))    dir_reg     <= req_wdata[GPIO_W-1:0];
         if (wr_en && addr_word == ADDR_W'(GPIO_IRQ_EN_OFF)) irq_en_reg  <= req_wdata[GPIO_W-1:0];
         if (wr_en && addr_word == ADDR_W'(GPIO_RISE_OFF))   rise_en_reg <= req_wdata[GPIO_W-1:0];
         if (wr_en && addr_word == ADDR_W'(GPIO_FALL_OFF))   fall_en_reg <= req_wdata[GPIO_W-1:0];
         status_reg   <= status_next;
         in_prev_reg  <= in_sync;
         gpio_out_reg <= out_reg;
         gpio_oe_reg  <= dir_reg;
         irq_reg      <= |(status_reg & irq_en_reg);
         // Ready is a flop so it stays low through reset and comes up one cycle after release.
         ready_reg    <= (state_next == IDLE);
         if (accept) begin
            rsp_rdata_reg <= req_we ? 32'h0 : rd_mux;
            rsp_err_reg   <= addr_err;
         end
      end
   end

   assign req_ready = ready_reg;
   assign rsp_valid = (state_reg == RESP);
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign gpio_out  = gpio_out_reg;
   assign gpio_oe   = gpio_oe_reg;
   assign irq       = irq_reg;

endmodule
